// File: rtl/data_capture_pkg.sv
// Shared types and defaults for the data_capture snapshot buffer.
package data_capture_pkg;

    localparam int DEFAULT_DEPTH = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        WAIT_TX = 2'd2,
        READOUT = 2'd3
    } captureState_t;

endpackage

// File: rtl/data_capture_ram.sv
// Simple dual-port snapshot RAM: synchronous write, registered read with 1-cycle latency.
module capture_ram
    import data_capture_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [15:0]       wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [15:0]       rdData
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wrEn) begin
            mem[wrAddr] <= wrData;
        end
    end

    // Read register doubles as the block's output word, so it holds between reads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdData <= '0;
        end else if (rdEn) begin
            rdData <= mem[rdAddr];
        end
    end

endmodule

// File: rtl/data_capture.sv
// Snapshot buffer: captures 2*DEPTH bytes as DEPTH 16-bit words on a strobe edge,
// then hands them out one word per accepted read.
//
//   state   | meaning
//   IDLE    | waiting for a strobe rising edge; buffer empty
//   CAPTURE | latching one byte per clock, writing a word every second byte
//   WAIT_TX | snapshot complete, waiting for readyToTransmit
//   READOUT | delivering words on dataRead while readyToTransmit is high
module data_capture
    import data_capture_pkg::*;
#(
    parameter int DEPTH  = DEFAULT_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  inputData,
    input  logic        dataCaptureStrobe,
    input  logic        dataRead,
    input  logic        readyToTransmit,
    output logic        dataReadyToRead,
    output logic        dataValid,
    output logic        dataEmpty,
    output logic [15:0] dataOut
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] WORD_CNT  = (ADDR_W + 1)'(DEPTH);

    captureState_t   state;
    logic            strbQ;
    logic            bytePhase;
    logic [7:0]      evenByte;
    logic [ADDR_W:0] wrPtr;
    logic [ADDR_W:0] rdPtr;
    logic [ADDR_W:0] rdPtrNext;
    logic            trigger;
    logic            wrEn;
    logic            readAccept;

    assign trigger    = dataCaptureStrobe & ~strbQ & (state == IDLE);
    assign wrEn       = (state == CAPTURE) & bytePhase;
    assign readAccept = (state == READOUT) & dataReadyToRead & dataRead;
    assign rdPtrNext  = rdPtr + {{ADDR_W{1'b0}}, readAccept};

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk    (clk),
        .rst    (rst),
        .wrEn   (wrEn),
        .wrAddr (wrPtr[ADDR_W-1:0]),
        .wrData ({evenByte, inputData}),
        .rdEn   (readAccept),
        .rdAddr (rdPtr[ADDR_W-1:0]),
        .rdData (dataOut)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            strbQ           <= 1'b0;
            bytePhase       <= 1'b0;
            evenByte        <= '0;
            wrPtr           <= '0;
            rdPtr           <= '0;
            dataReadyToRead <= 1'b0;
            dataValid       <= 1'b0;
            dataEmpty       <= 1'b1;
        end else begin
            strbQ     <= dataCaptureStrobe;
            dataValid <= readAccept;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        evenByte  <= inputData;
                        bytePhase <= 1'b1;
                        dataEmpty <= 1'b0;
                        state     <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    bytePhase <= ~bytePhase;
                    if (!bytePhase) begin
                        evenByte <= inputData;
                    end else begin
                        wrPtr <= wrPtr + 1'b1;
                        if (wrPtr == LAST_WORD) begin
                            state <= WAIT_TX;
                        end
                    end
                end
                WAIT_TX: begin
                    // rdPtr is zero here, so a full snapshot is always available.
                    if (readyToTransmit) begin
                        dataReadyToRead <= 1'b1;
                        state           <= READOUT;
                    end
                end
                READOUT: begin
                    rdPtr           <= rdPtrNext;
                    dataReadyToRead <= readyToTransmit && (rdPtrNext < WORD_CNT);
                    if (readAccept && (rdPtrNext == WORD_CNT)) begin
                        rdPtr     <= '0;
                        wrPtr     <= '0;
                        dataEmpty <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_capture.sv
// Randomized bench for data_capture against a transaction-level snapshot model.
module tb_data_capture;
    import data_capture_pkg::*;

    localparam int DEPTH  = 128;
    localparam int ADDR_W = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  inputData = '0;
    logic        dataCaptureStrobe = 1'b0;
    logic        dataRead = 1'b0;
    logic        readyToTransmit = 1'b0;
    logic        dataReadyToRead;
    logic        dataValid;
    logic        dataEmpty;
    logic [15:0] dataOut;

    int checks = 0;
    int failures = 0;

    data_capture #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .inputData         (inputData),
        .dataCaptureStrobe (dataCaptureStrobe),
        .dataRead          (dataRead),
        .readyToTransmit   (readyToTransmit),
        .dataReadyToRead   (dataReadyToRead),
        .dataValid         (dataValid),
        .dataEmpty         (dataEmpty),
        .dataOut           (dataOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 = empty, 1 = collecting bytes, 2 = holding a full snapshot.
    int          mMode = 0;
    int          mBytes = 0;
    int          mDelivered = 0;
    logic [7:0]  mBuf [2*DEPTH];
    logic        mPrevStrb = 1'b0;
    logic        expRdy = 1'b0;
    logic        expValid = 1'b0;
    logic        expEmpty = 1'b1;
    logic [15:0] expOut = '0;

    always @(posedge clk) begin : modelStep
        int   prevMode;
        logic accept;
        if (!rst) begin
            mMode = 0; mBytes = 0; mDelivered = 0; mPrevStrb = 1'b0;
            expRdy = 1'b0; expValid = 1'b0; expEmpty = 1'b1; expOut = '0;
        end else begin
            prevMode = mMode;
            accept   = expRdy && dataRead;
            expValid = accept;
            if (accept) begin
                expOut = {mBuf[2*mDelivered], mBuf[2*mDelivered+1]};
                mDelivered++;
                if (mDelivered == DEPTH) begin
                    mMode    = 0;
                    expEmpty = 1'b1;
                end
            end
            if (prevMode == 0 && dataCaptureStrobe && !mPrevStrb) begin
                mBuf[0]  = inputData;
                mBytes   = 1;
                mMode    = 1;
                expEmpty = 1'b0;
            end else if (prevMode == 1) begin
                mBuf[mBytes] = inputData;
                mBytes++;
                if (mBytes == 2*DEPTH) begin
                    mMode      = 2;
                    mDelivered = 0;
                end
            end
            expRdy    = (prevMode == 2) && readyToTransmit && (mDelivered < DEPTH);
            mPrevStrb = dataCaptureStrobe;
        end
    end

    logic [15:0] got [$];

    always @(posedge clk) begin
        #1;
        if (rst) begin
            check("dataReadyToRead", 32'(dataReadyToRead), 32'(expRdy));
            check("dataValid", 32'(dataValid), 32'(expValid));
            check("dataEmpty", 32'(dataEmpty), 32'(expEmpty));
            check("dataOut", 32'(dataOut), 32'(expOut));
            if (dataValid) got.push_back(dataOut);
        end
    end

    logic       countMode = 1'b1;
    logic [7:0] cnt = '0;

    task automatic step();
        @(negedge clk);
        inputData = countMode ? cnt : 8'($urandom);
        cnt++;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic strobeAt(input logic [7:0] v);
        countMode = 1'b1;
        cnt = v;
        step();
        dataCaptureStrobe = 1'b1;
    endtask

    task automatic waitRdy(input string name);
        int n = 0;
        while (!dataReadyToRead && n < 2*DEPTH + 10) begin
            step();
            n++;
        end
        check(name, 32'(dataReadyToRead), 32'd1);
    endtask

    task automatic readN(input int n, input bit holdHigh, input string name);
        int done = 0;
        int guard = 0;
        while (done < n && guard < 20*n + 100) begin
            if (dataReadyToRead && (holdHigh || $urandom_range(0, 1) == 1)) begin
                dataRead = 1'b1;
                done++;
            end else begin
                dataRead = 1'b0;
            end
            step();
            guard++;
        end
        dataRead = 1'b0;
        check(name, 32'(done), 32'(n));
    endtask

    function automatic logic [15:0] patWord(input logic [7:0] base, input int k);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = base + 8'(2*k);
        lo = hi + 8'd1;
        return {hi, lo};
    endfunction

    task automatic checkPattern(input string name, input logic [7:0] base);
        int bad = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (k >= got.size() || got[k] !== patWord(base, k)) bad++;
        end
        check(name, 32'(bad), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        steps(3);
        rst = 1'b1;
        steps(20);
        check("t1 empty", 32'(dataEmpty), 32'd1);
        check("t1 rdy", 32'(dataReadyToRead), 32'd0);
        check("t1 valid", 32'(dataValid), 32'd0);
        check("t1 out", 32'(dataOut), 32'd0);

        // Counting capture with readyToTransmit high, read back-to-back
        readyToTransmit = 1'b1;
        got.delete();
        strobeAt(8'h10);
        steps(3);
        dataCaptureStrobe = 1'b0;
        waitRdy("t2 ready");
        readN(DEPTH, 1'b1, "t2 reads");
        steps(3);
        check("t2 count", 32'(got.size()), 32'(DEPTH));
        check("t2 word0", 32'(got[0]), 32'h1011);
        check("t2 word1", 32'(got[1]), 32'h1213);
        check("t2 last", 32'(got[DEPTH-1]), 32'h0E0F);
        checkPattern("t2 pattern", 8'h10);
        check("t2 empty", 32'(dataEmpty), 32'd1);

        // Capture with consumer not ready
        readyToTransmit = 1'b0;
        got.delete();
        strobeAt(8'h20);
        step();
        dataCaptureStrobe = 1'b0;
        for (int i = 0; i < 2*DEPTH + 20; i++) begin
            dataRead = 1'($urandom_range(0, 1));
            step();
        end
        dataRead = 1'b0;
        check("t3 rdy low", 32'(dataReadyToRead), 32'd0);
        check("t3 no valid", 32'(got.size()), 32'd0);
        readyToTransmit = 1'b1;
        readN(DEPTH, 1'b0, "t3 reads");
        steps(3);
        check("t3 word0", 32'(got[0]), 32'h2021);
        checkPattern("t3 pattern", 8'h20);

        // Consumer stalls after five words
        got.delete();
        strobeAt(8'h40);
        step();
        dataCaptureStrobe = 1'b0;
        waitRdy("t4 ready");
        readN(5, 1'b0, "t4 first reads");
        readyToTransmit = 1'b0;
        dataRead = 1'b0;
        step();
        for (int i = 0; i < 49; i++) begin
            dataRead = 1'($urandom_range(0, 1));
            step();
        end
        dataRead = 1'b0;
        check("t4 stalled rdy", 32'(dataReadyToRead), 32'd0);
        check("t4 stalled count", 32'(got.size()), 32'd5);
        readyToTransmit = 1'b1;
        readN(DEPTH - 5, 1'b0, "t4 rest reads");
        steps(3);
        check("t4 word5", 32'(got[5]), 32'h4A4B);
        checkPattern("t4 pattern", 8'h40);

        // Strobe activity outside IDLE
        got.delete();
        strobeAt(8'h80);
        steps(3);
        dataCaptureStrobe = 1'b0;
        steps(20);
        dataCaptureStrobe = 1'b1;
        steps(2);
        dataCaptureStrobe = 1'b0;
        waitRdy("t5 ready");
        readN(60, 1'b0, "t5 reads a");
        dataCaptureStrobe = 1'b1;
        step();
        dataCaptureStrobe = 1'b0;
        readN(DEPTH - 61, 1'b0, "t5 reads b");
        dataCaptureStrobe = 1'b1;
        readN(1, 1'b0, "t5 last read");
        steps(10);
        check("t5 held strobe empty", 32'(dataEmpty), 32'd1);
        check("t5 held strobe rdy", 32'(dataReadyToRead), 32'd0);
        check("t5 count", 32'(got.size()), 32'(DEPTH));
        checkPattern("t5 pattern", 8'h80);
        dataCaptureStrobe = 1'b0;
        step();
        got.delete();
        strobeAt(8'hA0);
        step();
        dataCaptureStrobe = 1'b0;
        check("t5 fresh edge", 32'(dataEmpty), 32'd0);
        waitRdy("t5 fresh ready");
        readN(DEPTH, 1'b1, "t5 fresh reads");
        steps(3);
        checkPattern("t5 fresh pattern", 8'hA0);

        // Reset mid-capture and mid-readout, random data
        countMode = 1'b0;
        step();
        dataCaptureStrobe = 1'b1;
        step();
        dataCaptureStrobe = 1'b0;
        steps(80);
        rst = 1'b0;
        #1;
        check("t6 capture rst empty", 32'(dataEmpty), 32'd1);
        check("t6 capture rst rdy", 32'(dataReadyToRead), 32'd0);
        steps(3);
        rst = 1'b1;
        steps(2);
        dataCaptureStrobe = 1'b1;
        step();
        dataCaptureStrobe = 1'b0;
        waitRdy("t6 ready a");
        readN(30, 1'b0, "t6 partial reads");
        rst = 1'b0;
        #1;
        check("t6 readout rst empty", 32'(dataEmpty), 32'd1);
        check("t6 readout rst rdy", 32'(dataReadyToRead), 32'd0);
        check("t6 readout rst out", 32'(dataOut), 32'd0);
        steps(3);
        rst = 1'b1;
        steps(2);
        dataCaptureStrobe = 1'b1;
        step();
        dataCaptureStrobe = 1'b0;
        waitRdy("t6 ready b");
        got.delete();
        readN(DEPTH, 1'b0, "t6 full reads");
        steps(3);
        check("t6 count", 32'(got.size()), 32'(DEPTH));
        check("t6 final empty", 32'(dataEmpty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
